// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: XLEN default, M-extension funct3 codes, MDU FSM states.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        CALC   = 2'd2,
        FINISH = 2'd3
    } mdu_state_t;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic f3_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM
    function automatic logic f3_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_sign_adj.sv
// Conditional two's-complement negate, used for operand abs and result sign fix.
module mdu_sign_adj #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    // Negate at full width when requested, otherwise pass through
    always_comb begin
        result = negate ? (~value + W'(1)) : value;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M unit: iterative shift-add multiply and restoring divide.
module mul_div_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);

    mdu_state_t      state, state_nxt;
    logic [2:0]      op;
    // hi/lo: product register for multiply; remainder/quotient pair for divide.
    // md: multiplicand or divisor. rs1 sits in lo and rs2 in md until PREP.
    logic [XLEN-1:0] hi, lo, md;
    logic [XLEN-1:0] result_q;
    logic            neg_q, neg_r;
    logic [CW-1:0]   cnt;

    logic            is_div, a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, quo_fix, rem_fix, res_fin;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN:0]   mul_sum, rem_sh, div_diff;

    mdu_sign_adj #(.W(XLEN))   u_abs_a (.value(lo), .negate(a_neg), .result(abs_a));
    mdu_sign_adj #(.W(XLEN))   u_abs_b (.value(md), .negate(b_neg), .result(abs_b));
    mdu_sign_adj #(.W(2*XLEN)) u_prod  (.value({hi, lo}), .negate(neg_q), .result(prod_fix));
    mdu_sign_adj #(.W(XLEN))   u_quo   (.value(lo), .negate(neg_q), .result(quo_fix));
    mdu_sign_adj #(.W(XLEN))   u_rem   (.value(hi), .negate(neg_r), .result(rem_fix));

    // Operand classification and per-iteration arithmetic
    always_comb begin
        is_div   = op[2];
        a_neg    = f3_signed_a(op) && lo[XLEN-1];
        b_neg    = f3_signed_b(op) && md[XLEN-1];
        div_zero = is_div && (md == '0);
        div_ovf  = is_div && !op[0] && (lo == {1'b1, {(XLEN-1){1'b0}}}) && (md == '1);
        special  = div_zero || div_ovf;
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
        rem_sh   = {hi, lo[XLEN-1]};
        div_diff = rem_sh - {1'b0, md};
    end

    // Final result selection from the sign-fixed registers
    always_comb begin
        res_fin = quo_fix;
        case (op)
            F3_MUL:                       res_fin = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res_fin = prod_fix[2*XLEN-1:XLEN];
            F3_REM, F3_REMU:              res_fin = rem_fix;
            default:                      res_fin = quo_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and status outputs; flush overrides everything
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == FINISH) && !flush;
        result    = done ? res_fin : result_q;
        case (state)
            IDLE:    if (start) state_nxt = PREP;
            PREP:    state_nxt = special ? FINISH : CALC;
            CALC:    if (cnt == '0) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Datapath: operand capture, abs/special-case prep, iteration, result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op       <= '0;
            hi       <= '0;
            lo       <= '0;
            md       <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: if (start) begin
                    op <= funct3;
                    lo <= rs1;
                    md <= rs2;
                    hi <= '0;
                end
                PREP: begin
                    cnt <= CW'(XLEN - 1);
                    hi  <= '0;
                    if (div_zero) begin
                        lo    <= '1;
                        hi    <= lo;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (div_ovf) begin
                        lo    <= {1'b1, {(XLEN-1){1'b0}}};
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (is_div) begin
                        lo    <= abs_a;
                        md    <= abs_b;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                    end else begin
                        // multiplier goes in lo so its LSB steers each add
                        lo    <= abs_b;
                        md    <= abs_a;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        hi <= div_diff[XLEN] ? rem_sh[XLEN-1:0] : div_diff[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], ~div_diff[XLEN]};
                    end else begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                FINISH: result_q <= res_fin;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: behavioural reference model plus directed cases.
module tb_mul_div_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int n_chk = 0;
    int n_err = 0;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // RISC-V M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] w;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'(a);
        ub = longint'(b);
        w  = '0;
        case (f)
            3'd0: begin w = sa * sb; return w[31:0];  end
            3'd1: begin w = sa * sb; return w[63:32]; end
            3'd2: begin w = sa * ub; return w[63:32]; end
            3'd3: begin w = ua * ub; return w[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                w = sa / sb; return w[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                w = sa % sb; return w[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Model: one outstanding op, done a fixed number of edges after acceptance
    logic        m_pend;
    int          m_left;
    logic [31:0] m_res, m_next;

    // Update model at every active edge using the inputs sampled there
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
            m_next <= '0;
        end else if (m_pend) begin
            if (flush) m_pend <= 1'b0;
            else if (m_left == 0) begin
                m_res  <= m_next;
                m_pend <= 1'b0;
            end else m_left <= m_left - 1;
        end else if (start && !flush) begin
            m_pend <= 1'b1;
            m_left <= is_special(funct3, rs1, rs2) ? 1 : XLEN + 1;
            m_next <= ref_op(funct3, rs1, rs2);
        end
    end

    // Compare DUT outputs against the model mid-cycle
    always @(negedge clk) begin
        logic ed;
        ed = m_pend && (m_left == 0) && !flush;
        check("busy", {63'b0, busy}, {63'b0, m_pend});
        check("done", {63'b0, done}, {63'b0, ed});
        check("result", {32'b0, result}, {32'b0, ed ? m_next : m_res});
    end

    // Issue one op now and wait (bounded) for done; checks latency and result
    task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom_range(0, 7));
        cyc = 1;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, "_lat"}, 64'(cyc), 64'(lat));
        check(nm, {32'b0, result}, {32'b0, exp});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc, fl_at, seen;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_result", {32'b0, result}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        @(posedge clk); #1;
        do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        @(posedge clk); #1;
        do_op("mulhsu", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34);
        @(posedge clk); #1;
        do_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        @(posedge clk); #1;
        do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        @(posedge clk); #1;
        do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        @(posedge clk); #1;
        do_op("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);
        @(posedge clk); #1;
        do_op("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        @(posedge clk); #1;
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        @(posedge clk); #1;
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);
        @(posedge clk); #1;
        do_op("rem0", 3'd6, 32'd5, 32'd0, 32'd5, 2);
        @(posedge clk); #1;

        // flush during CALC iteration 10: unit idles, no done, result keeps 5
        funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {63'b0, busy}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("flush_nodone", 64'(seen), 64'd0);
        check("flush_result", {32'b0, result}, 64'd5);

        // flush and start together in IDLE: request dropped
        funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {63'b0, busy}, 64'd0);

        // start pulsed while busy is ignored; exactly one done
        funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) begin
                seen++;
                check("busy_start_res", {32'b0, result}, 64'd15);
            end
        end
        check("busy_start_ndone", 64'(seen), 64'd1);

        // start in the done cycle is dropped; the next cycle is accepted
        do_op("divu_b2b", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        funct3 = 3'd0; rs1 = 32'd6; rs2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        check("done_start_busy", {63'b0, busy}, 64'd0);
        do_op("mul_b2b", 3'd0, 32'd6, 32'd7, 32'd42, 34);
        @(posedge clk); #1;

        // asynchronous reset mid-CALC
        funct3 = 3'd3; rs1 = $urandom; rs2 = $urandom; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'b0, busy}, 64'd0);
        check("arst_done", {63'b0, done}, 64'd0);
        check("arst_result", {32'b0, result}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // randomized traffic with occasional flushes and stray starts
        for (int i = 0; i < 80; i++) begin
            funct3 = 3'($urandom_range(0, 7)); rs1 = pick(); rs2 = pick();
            start = 1'b1; flush = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0; rs1 = $urandom; rs2 = $urandom;
            fl_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 34)) : 0;
            cyc = 1;
            while (busy && cyc < 60) begin
                if (cyc == fl_at) flush = 1'b1;
                if ($urandom_range(0, 9) == 0) start = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0; start = 1'b0;
                cyc++;
            end
            if (cyc >= 60) check("rand_timeout", 64'(cyc), 64'd0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
